gtxe2_chnl_tx_buf: RTL

Single-clock TX elastic buffer for the GTXE2 channel model. It sits between the fabric-side TX inputs (TXDATA and its per-byte 8b/10b control) and the 8b/10b encoder / OOB arbiter stage of the transmitter. It absorbs short bursts between the user write cadence and the encoder read cadence, and reports health on TXBUFSTATUS with GTX semantics. It holds off reading after reset or flush until it is half full.

---
 rtl/gtxe2_chnl_tx_pkg.sv | 14 +
 rtl/gtxe2_chnl_tx_buf_ram.sv | 31 +++
 rtl/gtxe2_chnl_tx_buf.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/gtxe2_chnl_tx_pkg.sv
// Shared definitions for the GTXE2 TX channel model: buffer FSM encodings
// and TXBUFSTATUS bit positions.
package gtxe2_chnl_tx_pkg;

    typedef enum logic [1:0] {
        ST_FILL = 2'd0,
        ST_RUN  = 2'd1,
        ST_ERR  = 2'd2
    } buf_state_e;

    localparam int BUFSTAT_ERR  = 1;
    localparam int BUFSTAT_HALF = 0;

endpackage

// File: rtl/gtxe2_chnl_tx_buf_ram.sv
// Storage array for the TX elastic buffer: one synchronous write port and
// one asynchronous read port; contents cleared by reset.
module gtxe2_chnl_tx_buf_ram #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 24
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [WIDTH-1:0]         wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [WIDTH-1:0]         rdata
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    // Array write; reset clears every entry so the show-ahead head reads 0.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/gtxe2_chnl_tx_buf.sv
// Single-clock TX elastic buffer between the fabric TX inputs and the
// 8b/10b encoder. Holds off reads until half full after reset or flush.
//
// state   | meaning
// --------+-------------------------------------------------------------
// ST_FILL | accepting writes, no pops; moves to RUN once half full
// ST_RUN  | normal streaming; overflow/underflow move to ERR
// ST_ERR  | output invalid, writes/pops ignored until flush or reset
module gtxe2_chnl_tx_buf
    import gtxe2_chnl_tx_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH      = 8
) (
    input  logic                      TXUSRCLK,
    input  logic                      reset_n,
    input  logic                      buf_flush,
    input  logic [DATA_WIDTH-1:0]     TXDATA,
    input  logic [DATA_WIDTH/8-1:0]   TXCHARISK,
    input  logic [DATA_WIDTH/8-1:0]   TXCHARDISPMODE,
    input  logic [DATA_WIDTH/8-1:0]   TXCHARDISPVAL,
    input  logic [DATA_WIDTH/8-1:0]   TX8B10BBYPASS,
    input  logic                      in_val,
    input  logic                      out_rdy,
    output logic [DATA_WIDTH-1:0]     out_data,
    output logic [DATA_WIDTH/8-1:0]   out_charisk,
    output logic [DATA_WIDTH/8-1:0]   out_dispmode,
    output logic [DATA_WIDTH/8-1:0]   out_dispval,
    output logic [DATA_WIDTH/8-1:0]   out_bypass,
    output logic                      out_val,
    output logic [1:0]                TXBUFSTATUS
);

    localparam int NB = DATA_WIDTH / 8;
    localparam int EW = DATA_WIDTH + 4 * NB;
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
    localparam logic [CW-1:0] CNT_HALF = CW'(DEPTH / 2);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    buf_state_e    state_q, state_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          err_q, err_d;
    logic          do_wr, do_pop;
    logic [EW-1:0] wr_word, rd_word;

    assign wr_word = {TX8B10BBYPASS, TXCHARDISPVAL, TXCHARDISPMODE, TXCHARISK, TXDATA};

    // Next-state, pointer and occupancy update; flush overrides any traffic.
    always_comb begin
        state_d  = state_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        err_d    = err_q;
        do_wr    = 1'b0;
        do_pop   = 1'b0;
        if (buf_flush) begin
            state_d  = ST_FILL;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            cnt_d    = '0;
            err_d    = 1'b0;
        end else begin
            unique case (state_q)
                ST_FILL: begin
                    if (in_val) begin
                        if (cnt_q == CNT_FULL) begin
                            state_d = ST_ERR;
                            err_d   = 1'b1;
                        end else begin
                            do_wr = 1'b1;
                            if ((cnt_q + CNT_ONE) >= CNT_HALF) begin
                                state_d = ST_RUN;
                            end
                        end
                    end
                end
                ST_RUN: begin
                    do_pop = out_rdy && (cnt_q != '0);
                    if (out_rdy && (cnt_q == '0)) begin
                        // underflow still keeps a same-cycle write
                        state_d = ST_ERR;
                        err_d   = 1'b1;
                        do_wr   = in_val;
                    end else if (in_val && (cnt_q == CNT_FULL) && !do_pop) begin
                        state_d = ST_ERR;
                        err_d   = 1'b1;
                    end else begin
                        do_wr = in_val;
                    end
                end
                ST_ERR: begin
                end
                default: begin
                    state_d = ST_ERR;
                    err_d   = 1'b1;
                end
            endcase
            if (do_wr) begin
                wr_ptr_d = wr_ptr_q + PTR_ONE;
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + PTR_ONE;
            end
            cnt_d = cnt_q + {{(CW-1){1'b0}}, do_wr} - {{(CW-1){1'b0}}, do_pop};
        end
    end

    // Control registers.
    always_ff @(posedge TXUSRCLK or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_FILL;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            err_q    <= err_d;
        end
    end

    gtxe2_chnl_tx_buf_ram #(
        .DEPTH (DEPTH),
        .WIDTH (EW)
    ) u_ram (
        .clk     (TXUSRCLK),
        .reset_n (reset_n),
        .we      (do_wr),
        .waddr   (wr_ptr_q),
        .wdata   (wr_word),
        .raddr   (rd_ptr_q),
        .rdata   (rd_word)
    );

    assign {out_bypass, out_dispval, out_dispmode, out_charisk, out_data} = rd_word;
    assign out_val = (state_q == ST_RUN) && (cnt_q != '0);
    assign TXBUFSTATUS[BUFSTAT_ERR]  = err_q;
    assign TXBUFSTATUS[BUFSTAT_HALF] = (cnt_q >= CNT_HALF);

endmodule
